// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory bus between the memory stage and the data memory.
//   dmem_req   : access in flight (held high until ack or timeout)
//   dmem_we    : write strobe (1 = store)
//   dmem_addr  : word address, bits [1:0] always 0
//   dmem_wdata : store data replicated onto the byte lanes
//   dmem_be    : byte enables
//   dmem_rdata : read word returned by memory
//   dmem_ack   : access completion from memory
// master = memory stage, slave = memory.
interface mem_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory stage: turns execute-stage load/store results
// into single data-memory bus accesses and returns extended load data.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   valid_in              : execute result valid
//   mem_read, mem_write   : load / store request (both high = store)
//   funct3                : width / extension (LB LH LW LBU LHU; SB SH SW)
//   alu_result            : effective byte address
//   store_data            : right-aligned store source
//   bus                   : data-memory bus (mem_stage_if.master)
//   load_data             : registered, extended load result
//   done                  : one-cycle pulse when an access completes
//   stall                 : combinational upstream freeze
//   fault                 : one-cycle pulse on ack timeout (or trapped misalignment)
//
// Parameter ACK_TIMEOUT (1..255): WAIT cycles without ack before fault.
//
// Build option MEM_MISALIGN_TRAP_EN: when defined, misaligned half/word
// accesses are rejected with a fault; when undefined they are force-aligned
// and proceed normally.
module mem_stage #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        store_data,
    mem_stage_if.master        bus,
    output logic [31:0]        load_data,
    output logic               done,
    output logic               stall,
    output logic               fault
);
    localparam logic [7:0] TO = 8'(ACK_TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        is_half, is_word, misalign, trap;
    logic        req_hit, accept, trap_hit;
    logic [1:0]  off;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] shifted;
    logic [31:0] ld_n;

    assign is_half  = (funct3[1:0] == 2'b01);
    assign is_word  = funct3[1];
    assign misalign = (is_half && alu_result[0]) || (is_word && (alu_result[1:0] != 2'b00));

`ifdef MEM_MISALIGN_TRAP_EN
    assign off  = alu_result[1:0];
    assign trap = misalign;
`else
    // Force-align: drop the offending low address bits and carry on.
    assign off  = misalign ? (is_half ? {alu_result[1], 1'b0} : 2'b00) : alu_result[1:0];
    assign trap = 1'b0;
`endif

    assign req_hit  = valid_in && (mem_read || mem_write);
    assign accept   = (state == IDLE) && req_hit && !trap;
    assign trap_hit = (state == IDLE) && req_hit && trap;

    // Request is a pure decode of state so reset drops it without a clock.
    assign bus.dmem_req = (state == WAIT);
    assign stall        = (state == WAIT) || accept;

    always_comb begin
        be_n    = 4'b1111;
        wdata_n = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_n    = 4'b0001 << off;
                wdata_n = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_n    = 4'b0011 << off;
                wdata_n = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend.
    assign shifted = bus.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        ld_n = shifted;
        case (f3_q)
            3'b000:  ld_n = {{24{shifted[7]}},  shifted[7:0]};
            3'b001:  ld_n = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_n = {24'd0, shifted[7:0]};
            3'b101:  ld_n = {16'd0, shifted[15:0]};
            default: ld_n = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            f3_q           <= 3'd0;
            off_q          <= 2'd0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= 32'd0;
            bus.dmem_wdata <= 32'd0;
            bus.dmem_be    <= 4'b0000;
            load_data      <= 32'd0;
            done           <= 1'b0;
            fault          <= 1'b0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state          <= WAIT;
                        cnt            <= 8'd0;
                        f3_q           <= funct3;
                        off_q          <= off;
                        bus.dmem_we    <= mem_write;
                        bus.dmem_addr  <= {alu_result[31:2], 2'b00};
                        bus.dmem_be    <= be_n;
                        bus.dmem_wdata <= wdata_n;
                    end else if (trap_hit) begin
                        fault <= 1'b1;
                    end
                end
                WAIT: begin
                    // Ack takes priority over a timeout reached in the same cycle.
                    if (bus.dmem_ack) begin
                        state <= IDLE;
                        done  <= 1'b1;
                        if (!bus.dmem_we)
                            load_data <= ld_n;
                    end else if (cnt + 8'd1 == TO) begin
                        state <= IDLE;
                        fault <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    localparam int TO = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] alu_result = 32'd0, store_data = 32'd0;
    logic [31:0] load_data;
    logic        done, stall, fault;

    mem_stage_if bus();

    mem_stage #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .bus(bus), .load_data(load_data),
        .done(done), .stall(stall), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic        fault;
        logic [31:0] ld;
    } exp_t;

    exp_t        q[$];
    int          total = 0, bad = 0;
    logic [31:0] ld_model = 32'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference load extension, built byte-by-byte.
    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [7:0] by [4];
        for (int i = 0; i < 4; i++) by[i] = w[8*i +: 8];
        case (f3)
            3'b000:  return {{24{by[off][7]}}, by[off]};
            3'b100:  return {24'd0, by[off]};
            3'b001:  return {{16{by[off+2'd1][7]}}, by[off+2'd1], by[off]};
            3'b101:  return {16'd0, by[off+2'd1], by[off]};
            default: return w;
        endcase
    endfunction

    // Scoreboard: every done/fault pulse pops one expected outcome.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done === 1'b1 || fault === 1'b1)) begin
            if (q.size() == 0) begin
                chk("unexpected_evt", {30'd0, done, fault}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("done", {31'd0, done}, {31'd0, e.done});
                chk("fault", {31'd0, fault}, {31'd0, e.fault});
                chk("load_data", load_data, e.ld);
            end
        end
    end

    // ack_at: WAIT cycle carrying ack (1 = first); 0 or > TO means never.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input logic [31:0] rw, input int ack_at);
        logic mis, trapped, tmo;
        logic [1:0] off;
        logic [3:0] ebe;
        logic [31:0] ewd;
        exp_t e;
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        trapped = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        trapped = mis;
`endif
        off = a[1:0];
        if (mis) off = (f3[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
        case (f3[1:0])
            2'b00:   begin ebe = 4'b0001 << off; ewd = {4{sd[7:0]}};  end
            2'b01:   begin ebe = 4'b0011 << off; ewd = {2{sd[15:0]}}; end
            default: begin ebe = 4'b1111;        ewd = sd;            end
        endcase
        tmo = (ack_at < 1) || (ack_at > TO);
        if (trapped || tmo) begin
            e = '{1'b0, 1'b1, ld_model};
        end else begin
            if (!wr) ld_model = ext_load(f3, off, rw);
            e = '{1'b1, 1'b0, ld_model};
        end
        q.push_back(e);

        @(negedge clk);
        valid_in = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; alu_result = a; store_data = sd;
        #1 chk("stall_accept", {31'd0, stall}, {31'd0, !trapped});
        @(posedge clk);
        #1 valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;

        if (trapped) begin
            @(negedge clk);
            #1 chk("req_trap", {31'd0, bus.dmem_req}, 32'd0);
        end else begin
            for (int n = 1; n <= TO; n++) begin
                @(negedge clk);
                chk("req_wait", {31'd0, bus.dmem_req}, 32'd1);
                chk("stall_wait", {31'd0, stall}, 32'd1);
                if (n == 1) begin
                    chk("addr", bus.dmem_addr, {a[31:2], 2'b00});
                    chk("we", {31'd0, bus.dmem_we}, {31'd0, wr});
                    chk("be", {28'd0, bus.dmem_be}, {28'd0, ebe});
                    if (wr) chk("wdata", bus.dmem_wdata, ewd);
                end
                bus.dmem_rdata = rw;
                bus.dmem_ack = (n == ack_at);
                @(posedge clk);
                #1 bus.dmem_ack = 1'b0;
                if (n == ack_at) break;
            end
        end
    endtask

    // Idle the inputs until the scoreboard empties; lat = cycles taken.
    task automatic drain(output int lat);
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 lat++;
            if (i == 0) begin
                chk("req_after", {31'd0, bus.dmem_req}, 32'd0);
                chk("stall_after", {31'd0, stall}, 32'd0);
            end
            if (q.size() == 0) break;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        int lat;
        bus.dmem_rdata = 32'd0;
        bus.dmem_ack   = 1'b0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("rst_we", {31'd0, bus.dmem_we}, 32'd0);
        chk("rst_addr", bus.dmem_addr, 32'd0);
        chk("rst_wdata", bus.dmem_wdata, 32'd0);
        chk("rst_be", {28'd0, bus.dmem_be}, 32'd0);
        chk("rst_load", load_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        #10 rst_n = 1'b1;

        // LW 0x100, ack first cycle, done on the cycle right after ack
        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        drain(lat);
        chk("lw_latency", lat, 32'd1);
        chk("lw_value", load_data, 32'hDEADBEEF);

        // LB / LBU 0x103
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1); drain(lat);
        chk("lb_value", load_data, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 1); drain(lat);
        chk("lbu_value", load_data, 32'h00000080);

        // SH 0x202 leaves load_data alone
        access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'hFFFFFFFF, 1); drain(lat);
        chk("sh_keep_load", load_data, 32'h00000080);

        // LH / LHU / SB / SW / store-wins-when-both
        access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 2); drain(lat);
        chk("lh_value", load_data, 32'hFFFF8001);
        access(1, 0, 3'b101, 32'h100, 32'h0, 32'h1234F00D, 1); drain(lat);
        access(0, 1, 3'b000, 32'h201, 32'h00000055, 32'h0, 1); drain(lat);
        access(1, 1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 2); drain(lat);

        // Timeout with no ack, then ack on the last allowed cycle
        access(1, 0, 3'b010, 32'h104, 32'h0, 32'h11111111, 0); drain(lat);
        access(1, 0, 3'b010, 32'h104, 32'h0, 32'h22222222, TO); drain(lat);
        chk("ack_at_limit", load_data, 32'h22222222);

        // Back-to-back: second access accepted on the done cycle
        access(1, 0, 3'b000, 32'h001, 32'h0, 32'h0000A500, 1);
        access(1, 0, 3'b101, 32'h002, 32'h0, 32'h7FFE0000, 1);
        drain(lat);
        chk("b2b_value", load_data, 32'h00007FFE);

        // Misaligned LW 0x101
        access(1, 0, 3'b010, 32'h101, 32'h0, 32'h5A5AA5A5, 1); drain(lat);

        // Ack while idle is ignored
        @(negedge clk); bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h0BADF00D;
        @(posedge clk); #1 bus.dmem_ack = 1'b0;
        drain(lat);
        chk("idle_ack_load", load_data, ld_model);

        // valid_in without read/write: no stall, no request
        @(negedge clk); valid_in = 1'b1; funct3 = 3'b010; alu_result = 32'h500;
        #1 chk("nop_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1 valid_in = 1'b0;
        drain(lat);

        // Reset during WAIT drops req immediately, no done/fault afterwards
        @(negedge clk); valid_in = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h400;
        @(posedge clk); #1 valid_in = 1'b0; mem_read = 1'b0;
        #1 chk("pre_rst_req", {31'd0, bus.dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1 chk("mid_rst_req", {31'd0, bus.dmem_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);
        #13 rst_n = 1'b1;
        ld_model = 32'd0;
        drain(lat);
        drain(lat);
        chk("post_rst_load", load_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15: maximum number of WAIT cycles without dmem_ack before a fault is raised; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 valid_in  input  1  execute-stage result valid this cycle.
REQ-005 mem_read / mem_write  input  1 each  load / store request; both high is treated as a store.
REQ-006 funct3  input  3  access width and extension: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
REQ-007 alu_result  input  32  effective byte address.
REQ-008 store_data  input  32  store source (rs2), right-aligned.
REQ-009 dmem_req, dmem_we  output  1 each  bus request and write strobe.
REQ-010 dmem_addr  output  32  word address, with bits [1:0] = 0.
REQ-011 dmem_wdata  output  32  lane-shifted store data.
REQ-012 dmem_be  output  4  byte enables.
REQ-013 dmem_rdata  input  32  read word.
REQ-014 dmem_ack  input  1  bus completion.
REQ-015 load_data  output  32  extended load result, registered.
REQ-016 done  output  1  one-cycle pulse when an access completes.
REQ-017 stall  output  1  freeze upstream stages; combinational.
REQ-018 fault  output  1  one-cycle pulse on timeout or misaligned access.

Function
REQ-019 States: IDLE and WAIT; no other states.
REQ-020 IDLE accepts an access when valid_in is high and (mem_read or mem_write) is high; on that edge it latches the request and enters WAIT.
REQ-021 Latched request values: dmem_addr = {alu_result[31:2], 2'b00}; dmem_we = mem_write; dmem_be and dmem_wdata per REQ-022.
REQ-022 Byte lane selection: byte access gives be = 1 << a[1:0] and wdata = {4{sd[7:0]}}; half access gives be = 0011 << a[1:0] and wdata = {2{sd[15:0]}}; word access gives be = 1111 and wdata = sd.
REQ-023 dmem_req is high exactly while in WAIT; addr, we, be and wdata are held stable while dmem_req is high.
REQ-024 An ack sampled high in WAIT ends the access: state returns to IDLE, done pulses high the next cycle, and dmem_req drops.
REQ-025 Loads: on ack, select the addressed lane, sign-extend for LB/LH or zero-extend for LBU/LHU/LW, and register the result into load_data.
REQ-026 load_data is held until the next load completes; stores do not change it.
REQ-027 Minimum latency: accept edge, then 1 WAIT cycle with ack high, then done; total of 2 cycles from accept to done.
REQ-028 stall = (state == WAIT) or (IDLE and an access is being accepted); stall is 0 on the done cycle.
REQ-029 A timeout counter clears on entry to WAIT and increments on each WAIT cycle without ack.
REQ-030 Timeout: when the counter reaches ACK_TIMEOUT, return to IDLE, pulse fault, leave done low and leave load_data unchanged.
REQ-031 An ack arriving in the same cycle the timeout is reached wins: the access completes normally and fault stays low.
REQ-032 dmem_ack in IDLE is ignored.
REQ-033 valid_in without mem_read or mem_write issues no request, and stall, done and fault all stay 0.
REQ-034 Back-to-back accesses: a new access may be accepted in the IDLE cycle in which done is high.

Reset
REQ-035 While rst_n is low, regardless of clk: state = IDLE; dmem_req, dmem_we, done, fault = 0; dmem_addr, dmem_wdata, load_data = 0; dmem_be = 0000; counter = 0.
REQ-036 Reset asserted mid-WAIT abandons the access: dmem_req drops immediately, and no done or fault is produced.

Configuration
REQ-037 Macro MEM_MISALIGN_TRAP_EN controls misalignment handling.
REQ-038 With MEM_MISALIGN_TRAP_EN defined, a misaligned access (half with a[0] = 1, or word with a[1:0] != 0) issues no request, stays in IDLE, and pulses fault the next cycle.
REQ-039 With MEM_MISALIGN_TRAP_EN undefined, a misaligned access forces a[0] = 0 (half) or a[1:0] = 0 (word), proceeds normally, and never raises fault for misalignment.

Verification
REQ-040 LW at 0x100, dmem_rdata = 0xDEADBEEF, ack in the first WAIT cycle -> dmem_addr = 0x100, be = 1111, done 2 cycles after accept, load_data = 0xDEADBEEF.
REQ-041 LB at 0x103 with rdata = 0x80FF1234 -> load_data = 0xFFFFFF80; LBU at the same address -> load_data = 0x00000080.
REQ-042 SH at 0x202 with store_data = 0x0000ABCD -> dmem_we = 1, be = 1100, wdata = 0xABCDABCD, load_data unchanged.
REQ-043 ACK_TIMEOUT = 3 with no ack -> req high for 3 cycles, fault pulses, done stays 0; repeat with ack on cycle 3 -> done pulses and fault stays 0.
REQ-044 LW at 0x101 -> with MEM_MISALIGN_TRAP_EN: no req, fault pulses; without it: dmem_addr = 0x100 and done pulses.
REQ-045 rst_n pulled low during WAIT -> dmem_req falls without a clock edge; after release, state is IDLE and no done is produced.
